// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the counter run controller
//
// Purpose: run-controller FSM state encoding and default geometry.
// Ports: none (package).
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among requesters
//
// Purpose: choose one requester, searching upward from the slot after
//          the last one served and wrapping modulo NREQ.
// Ports:
//   req      in  NREQ  request vector
//   last     in  LW    index of the requester served last
//   win      out NREQ  one-hot winner, zero when no request
//   win_idx  out LW    index of the winner (don't-care when win is zero)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [LW-1:0]   win_idx
);

  logic          found;
  logic [LW-1:0] idx;

  // k runs 1..NREQ so the last-served requester is considered last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - round-robin owner of a shared up-counter with wrap detection
//
// Purpose: grants the counter to one requester at a time, loads its start
//          value, increments count_len times, then pulses done to the owner
//          together with a sticky wrap flag.
// Ports:
//   clk        in  1           rising-edge clock
//   r          in  1           synchronous active-low reset
//   req        in  NREQ        level run request per requester
//   start_val  in  NREQ*WIDTH  start value, slice i = [i*WIDTH +: WIDTH]
//   count_len  in  NREQ*WIDTH  increment count, same slicing
//   gnt        out NREQ        one-hot owner, LOAD through DONE
//   busy       out 1           any state other than IDLE
//   cnt        out WIDTH       counter value
//   done       out NREQ        one-cycle pulse to owner at end of run
//   overflow   out 1           run wrapped max->0; held until next LOAD
module counter_run_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_val,
  input  logic [NREQ*WIDTH-1:0] count_len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt,
  output logic [NREQ-1:0]       done,
  output logic                  overflow
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, next_state;
  logic [NREQ-1:0]   gnt_q;
  logic [LW-1:0]     gidx_q;
  logic [LW-1:0]     last_q;
  logic [WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]  rem_q;
  logic              ovf_q;

  logic [NREQ-1:0]   win;
  logic [LW-1:0]     win_idx;
  logic [WIDTH-1:0]  sel_start;
  logic [WIDTH-1:0]  sel_len;

  rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_arb (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // Owner's operands, selected by the registered grant index.
  assign sel_start = WIDTH'(start_val >> (int'(gidx_q) * WIDTH));
  assign sel_len   = WIDTH'(count_len >> (int'(gidx_q) * WIDTH));

  always_ff @(posedge clk) begin
    if (!r) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) next_state = LOAD;
      end
      LOAD: begin
        next_state = (sel_len == '0) ? DONE : RUN;
      end
      RUN: begin
        // rem_q counts the increment happening at this edge.
        if (rem_q == WIDTH'(1)) next_state = DONE;
      end
      DONE: begin
        done       = gnt_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      gnt_q  <= '0;
      gidx_q <= '0;
      last_q <= LW'(NREQ - 1);
      cnt_q  <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_q  <= win;
            gidx_q <= win_idx;
          end
        end
        LOAD: begin
          cnt_q <= sel_start;
          rem_q <= sel_len;
          ovf_q <= 1'b0;
        end
        RUN: begin
          cnt_q <= cnt_q + WIDTH'(1);
          rem_q <= rem_q - WIDTH'(1);
          // Wrap is seen on the FF->00 step only; sticky for the run.
          if (cnt_q == '1) ovf_q <= 1'b1;
        end
        DONE: begin
          gnt_q  <= '0;
          last_q <= gidx_q;
        end
        default: ;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign cnt      = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - self-checking bench for counter_run_ctrl
module tb_counter_run_ctrl;

  logic        clk = 1'b0;
  logic        r;
  logic [1:0]  req;
  logic [7:0]  sv0, sv1, cl0, cl1;
  logic [15:0] start_val, count_len;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  cnt;
  logic [1:0]  done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  assign start_val = {sv1, sv0};
  assign count_len = {cl1, cl0};

  always #5 clk = ~clk;

  counter_run_ctrl #(.WIDTH(8), .NREQ(2)) dut (
    .clk       (clk),
    .r         (r),
    .req       (req),
    .start_val (start_val),
    .count_len (count_len),
    .gnt       (gnt),
    .busy      (busy),
    .cnt       (cnt),
    .done      (done),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph = edges since the grant (0 = idle). Counter value and wrap
  // follow in closed form from start + increments done so far.
  bit mvalid = 1'b0;
  int ph, mw, mlast, ms, ml, mcnt;
  bit movf;

  always @(posedge clk) begin
    if (!r) begin
      mvalid = 1'b1;
      ph = 0; mcnt = 0; movf = 1'b0; mlast = 1; mw = 0; ms = 0; ml = 0;
    end else if (mvalid) begin
      if (ph == 0) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 2; k++) begin
          int i;
          i = (mlast + k) % 2;
          if (!found && (((req >> i) & 2'b01) != 2'b00)) begin
            mw = i;
            found = 1'b1;
          end
        end
        if (found) ph = 1;
      end else if (ph == 1) begin
        ms = (mw == 0) ? int'(sv0) : int'(sv1);
        ml = (mw == 0) ? int'(cl0) : int'(cl1);
        ph = 2;
        mcnt = ms;
        movf = 1'b0;
      end else if (ph - 2 == ml) begin
        ph = 0;
        mlast = mw;
      end else begin
        ph++;
        mcnt = (ms + ph - 2) % 256;
        movf = (ms + ph - 2) >= 256;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_gnt", int'(gnt), (ph >= 1) ? (1 << mw) : 0);
      chk("model_busy", int'(busy), (ph != 0) ? 1 : 0);
      chk("model_cnt", int'(cnt), mcnt);
      chk("model_done", int'(done), (ph >= 2 && ph - 2 == ml) ? (1 << mw) : 0);
      chk("model_ovf", int'(overflow), int'(movf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int max, output logic [1:0] d);
    bit seen;
    seen = 1'b0;
    d = 2'b00;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (done != 2'b00) begin
        d = done;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  logic [1:0] d;
  logic [1:0] exp_seq [4];

  initial begin
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    r = 1'b0; req = 2'b11;
    sv0 = 8'hFD; cl0 = 8'd5; sv1 = 8'h10; cl1 = 8'd0;

    // Reset held two cycles with both requests up.
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Release: requester 0 wins first; it runs FD for 5 increments.
    r = 1'b1;
    tick();
    chk("first_gnt", int'(gnt), 2'b01);
    req = 2'b01;
    tick();
    chk("single_load_cnt", int'(cnt), 8'hFD);
    wait_done(20, d);
    chk("single_done", int'(d), 2'b01);
    chk("single_cnt", int'(cnt), 8'h02);
    chk("single_ovf", int'(overflow), 1);
    req = 2'b00;
    tick(); tick();

    // Zero-length run on requester 1.
    req = 2'b10;
    tick();
    chk("zero_gnt", int'(gnt), 2'b10);
    tick();
    chk("zero_done", int'(done), 2'b10);
    chk("zero_cnt", int'(cnt), 8'h10);
    chk("zero_ovf", int'(overflow), 0);
    req = 2'b00;
    tick(); tick();

    // Contention: alternating grants.
    sv0 = 8'h20; cl0 = 8'd3; sv1 = 8'h30; cl1 = 8'd3;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_done(20, d);
      chk("cont_done", int'(d), int'(exp_seq[j]));
      chk("cont_ovf", int'(overflow), 0);
    end
    req = 2'b00;
    tick(); tick();

    // Full range.
    sv0 = 8'h00; cl0 = 8'd255; req = 2'b01;
    wait_done(300, d);
    chk("full0_cnt", int'(cnt), 8'hFF);
    chk("full0_ovf", int'(overflow), 0);
    req = 2'b00;
    tick(); tick();
    sv0 = 8'h01; req = 2'b01;
    wait_done(300, d);
    chk("full1_cnt", int'(cnt), 8'h00);
    chk("full1_ovf", int'(overflow), 1);
    req = 2'b00;
    tick(); tick();

    // Reset during RUN at cnt=42.
    sv1 = 8'h3A; cl1 = 8'd100; req = 2'b10;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
        tick();
        if (cnt == 8'h42 && busy) hit = 1'b1;
      end
      if (!hit) begin
        checks++;
        errors++;
        $display("FAIL midrst_reach: cnt never reached 42");
      end
    end
    r = 1'b0;
    tick();
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cnt", int'(cnt), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_ovf", int'(overflow), 0);
    r = 1'b1;
    tick();
    chk("midrst_regnt", int'(gnt), 2'b10);
    wait_done(150, d);
    chk("midrst_rerun_done", int'(d), 2'b10);
    req = 2'b00;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
